// File: rtl/generator_n.sv
// Nested-loop value generator: DELAY then RUN over NUM_LOOPS nested counters, adding a per-level step.
// Optional GENERATOR_N_CONTINUOUS_EN adds cont_i, which restarts the sequence instead of finishing.
module generator_n #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PERIOD_W  = 16,
  parameter int unsigned ITER_W    = 16,
  parameter int unsigned DELAY_W   = 7,
  parameter int unsigned NUM_LOOPS = 3,
  localparam int unsigned IterInW  = (NUM_LOOPS > 1) ? (NUM_LOOPS - 1) * ITER_W : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run_i,
  input  logic                          ready_i,
  input  logic [DATA_W-1:0]             start_i,
  input  logic [PERIOD_W-1:0]           per_i,
  input  logic [PERIOD_W-1:0]           duty_i,
  input  logic [DELAY_W-1:0]            delay_i,
  input  logic [IterInW-1:0]            iter_i,
  input  logic [NUM_LOOPS*DATA_W-1:0]   step_i,
`ifdef GENERATOR_N_CONTINUOUS_EN
  input  logic                          cont_i,
`endif
  output logic                          valid_o,
  output logic [DATA_W-1:0]             data_o,
  output logic                          last_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned OuterN = (NUM_LOOPS > 1) ? NUM_LOOPS - 1 : 1;
  localparam int unsigned OuterW = OuterN * ITER_W;

  typedef enum logic [1:0] {StIdle, StDelay, StRun, StDone} state_e;

  state_e                      state_q, state_d;
  logic [DELAY_W-1:0]          dly_q, dly_d;
  logic [PERIOD_W-1:0]         c0_q, c0_d;
  logic [OuterW-1:0]           ck_q, ck_d;
  logic [PERIOD_W-1:0]         per_q, per_d;
  logic [PERIOD_W-1:0]         duty_q, duty_d;
  logic [OuterW-1:0]           iter_q, iter_d;
  logic [NUM_LOOPS*DATA_W-1:0] step_q, step_d;
  logic [DATA_W-1:0]           data_q, data_d;
`ifdef GENERATOR_N_CONTINUOUS_EN
  logic [DATA_W-1:0]           start_q, start_d;
`endif
  logic                        valid_q, valid_d;
  logic                        last_q, last_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        carry;
  logic                        last_now;

  // Zero-length counts behave as length 1, so the terminal index saturates at 0.
  function automatic logic [PERIOD_W-1:0] per_last(input logic [PERIOD_W-1:0] p);
    return (p == '0) ? '0 : p - PERIOD_W'(1);
  endfunction

  function automatic logic [ITER_W-1:0] iter_last(input logic [ITER_W-1:0] it);
    return (it == '0) ? '0 : it - ITER_W'(1);
  endfunction

  function automatic logic seq_last(input logic [PERIOD_W-1:0] c0, input logic [PERIOD_W-1:0] p,
                                    input logic [OuterW-1:0] ck, input logic [OuterW-1:0] it);
    logic t;
    t = (c0 == per_last(p));
    for (int k = 0; k < int'(NUM_LOOPS) - 1; k++) begin
      t = t & (ck[k*ITER_W +: ITER_W] == iter_last(it[k*ITER_W +: ITER_W]));
    end
    return t;
  endfunction

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    c0_d     = c0_q;
    ck_d     = ck_q;
    per_d    = per_q;
    duty_d   = duty_q;
    iter_d   = iter_q;
    step_d   = step_q;
    data_d   = data_q;
`ifdef GENERATOR_N_CONTINUOUS_EN
    start_d  = start_q;
`endif
    carry    = 1'b0;
    last_now = seq_last(c0_q, per_q, ck_q, iter_q);

    if (run_i) begin
      per_d   = per_i;
      duty_d  = duty_i;
      iter_d  = OuterW'(iter_i);
      step_d  = step_i;
      data_d  = start_i;
`ifdef GENERATOR_N_CONTINUOUS_EN
      start_d = start_i;
`endif
      c0_d    = '0;
      ck_d    = '0;
      dly_d   = delay_i;
      state_d = (delay_i != '0) ? StDelay : StRun;
    end else begin
      case (state_q)
        StDelay: begin
          if (ready_i) begin
            if (dly_q <= DELAY_W'(1)) begin
              dly_d   = '0;
              state_d = StRun;
            end else begin
              dly_d = dly_q - DELAY_W'(1);
            end
          end
        end
        StRun: begin
          if (ready_i) begin
            if (last_now) begin
`ifdef GENERATOR_N_CONTINUOUS_EN
              if (cont_i) begin
                data_d = start_q;
                c0_d   = '0;
                ck_d   = '0;
              end else begin
                state_d = StDone;
              end
`else
              state_d = StDone;
`endif
            end else begin
              // Ripple from level 0 upward: terminal levels wrap, first non-terminal one steps.
              if (c0_q == per_last(per_q)) begin
                c0_d  = '0;
                carry = 1'b1;
              end else begin
                c0_d   = c0_q + PERIOD_W'(1);
                data_d = data_q + step_q[DATA_W-1:0];
              end
              for (int k = 0; k < int'(NUM_LOOPS) - 1; k++) begin
                if (carry) begin
                  if (ck_q[k*ITER_W +: ITER_W] == iter_last(iter_q[k*ITER_W +: ITER_W])) begin
                    ck_d[k*ITER_W +: ITER_W] = '0;
                  end else begin
                    ck_d[k*ITER_W +: ITER_W] = ck_q[k*ITER_W +: ITER_W] + ITER_W'(1);
                    data_d = data_q + step_q[(k+1)*DATA_W +: DATA_W];
                    carry  = 1'b0;
                  end
                end
              end
            end
          end
        end
        default: ;
      endcase
    end

    valid_d = (state_d == StRun) && (c0_d < duty_d);
    last_d  = (state_d == StRun) && seq_last(c0_d, per_d, ck_d, iter_d);
    busy_d  = (state_d == StDelay) || (state_d == StRun);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dly_q   <= '0;
      c0_q    <= '0;
      ck_q    <= '0;
      per_q   <= '0;
      duty_q  <= '0;
      iter_q  <= '0;
      step_q  <= '0;
      data_q  <= '0;
`ifdef GENERATOR_N_CONTINUOUS_EN
      start_q <= '0;
`endif
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      c0_q    <= c0_d;
      ck_q    <= ck_d;
      per_q   <= per_d;
      duty_q  <= duty_d;
      iter_q  <= iter_d;
      step_q  <= step_d;
      data_q  <= data_d;
`ifdef GENERATOR_N_CONTINUOUS_EN
      start_q <= start_d;
`endif
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_generator_n.sv
// Directed bench for generator_n: a 32-bit two-level instance and an 8-bit single-level instance.
module tb_generator_n;

  logic        clk;
  logic        rst_n;
  logic        run_a, run_b, ready, cont;
  logic [31:0] start_a;
  logic [7:0]  start_b;
  logic [15:0] per, duty, iter;
  logic [6:0]  delay;
  logic [63:0] step_a;
  logic [7:0]  step_b;
  logic        va, la, ba, dna;
  logic [31:0] da;
  logic        vb, lb, bb, dnb;
  logic [7:0]  db;
  logic [35:0] obs_a;
  logic [11:0] obs_b;
  int          n_checks = 0;
  int          n_fail   = 0;

  generator_n #(.DATA_W(32), .NUM_LOOPS(2)) u_main (
    .clk(clk), .rst_n(rst_n), .run_i(run_a), .ready_i(ready), .start_i(start_a),
    .per_i(per), .duty_i(duty), .delay_i(delay), .iter_i(iter), .step_i(step_a),
`ifdef GENERATOR_N_CONTINUOUS_EN
    .cont_i(cont),
`endif
    .valid_o(va), .data_o(da), .last_o(la), .busy_o(ba), .done_o(dna)
  );

  generator_n #(.DATA_W(8), .NUM_LOOPS(1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .run_i(run_b), .ready_i(ready), .start_i(start_b),
    .per_i(per), .duty_i(duty), .delay_i(delay), .iter_i(1'b0), .step_i(step_b),
`ifdef GENERATOR_N_CONTINUOUS_EN
    .cont_i(cont),
`endif
    .valid_o(vb), .data_o(db), .last_o(lb), .busy_o(bb), .done_o(dnb)
  );

  assign obs_a = {va, la, ba, dna, da};
  assign obs_b = {vb, lb, bb, dnb, db};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [35:0] mk(input logic v, input logic l, input logic b, input logic dn,
                                     input logic [31:0] d);
    return {v, l, b, dn, d};
  endfunction

  task automatic cfg_a(input logic [31:0] s, input logic [15:0] p, input logic [15:0] du,
                       input logic [15:0] it, input logic [31:0] s1, input logic [31:0] s0,
                       input logic [6:0] dl);
    start_a = s; per = p; duty = du; iter = it; step_a = {s1, s0}; delay = dl;
  endtask

  task automatic pulse_run_a();
    @(posedge clk); #1 run_a = 1'b1;
    @(posedge clk); #1 run_a = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_a !== 36'd0) begin
      n_fail++; $display("FAIL reset_main: got %h want %h", obs_a, 36'd0);
    end
    n_checks++;
    if (obs_b !== 12'd0) begin
      n_fail++; $display("FAIL reset_w8: got %h want %h", obs_b, 12'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] ed [4] = '{32'd10, 32'd13, 32'd16, 32'd19};
    logic [35:0] want;
    cfg_a(32'd10, 16'd4, 16'd4, 16'd0, 32'd100, 32'd3, 7'd0);
    pulse_run_a();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) want = mk(1'b1, i == 3, 1'b1, 1'b0, ed[i]);
      else       want = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd19);
      n_checks++;
      if (obs_a !== want) begin
        n_fail++; $display("FAIL basic slot %0d: got %h want %h", i, obs_a, want);
      end
    end
  endtask

  task automatic test_nested();
    logic [31:0] ed [6] = '{32'd0, 32'd1, 32'd2, 32'd10, 32'd11, 32'd12};
    logic        ev [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [35:0] want;
    cfg_a(32'd0, 16'd3, 16'd2, 16'd2, 32'd8, 32'd1, 7'd2);
    pulse_run_a();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      want = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      n_checks++;
      if (obs_a !== want) begin
        n_fail++; $display("FAIL nested delay %0d: got %h want %h", i, obs_a, want);
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      want = mk(ev[i], i == 5, 1'b1, 1'b0, ed[i]);
      n_checks++;
      if (obs_a !== want) begin
        n_fail++; $display("FAIL nested slot %0d: got %h want %h", i, obs_a, want);
      end
    end
    @(negedge clk);
    want = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd12);
    n_checks++;
    if (obs_a !== want) begin
      n_fail++; $display("FAIL nested done: got %h want %h", obs_a, want);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ed  [6] = '{32'd10, 32'd13, 32'd13, 32'd13, 32'd16, 32'd19};
    logic        rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [35:0] want;
    cfg_a(32'd10, 16'd4, 16'd4, 16'd0, 32'd100, 32'd3, 7'd0);
    pulse_run_a();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      want = mk(1'b1, i == 5, 1'b1, 1'b0, ed[i]);
      n_checks++;
      if (obs_a !== want) begin
        n_fail++; $display("FAIL stall slot %0d: got %h want %h", i, obs_a, want);
      end
      ready = rdy[i];
    end
    @(negedge clk);
    want = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd19);
    n_checks++;
    if (obs_a !== want) begin
      n_fail++; $display("FAIL stall done: got %h want %h", obs_a, want);
    end
    ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [35:0] want;
    cfg_a(32'd10, 16'd4, 16'd4, 16'd0, 32'd100, 32'd3, 7'd0);
    pulse_run_a();
    repeat (3) @(negedge clk);
    want = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'd16);
    n_checks++;
    if (obs_a !== want) begin
      n_fail++; $display("FAIL rstmid before: got %h want %h", obs_a, want);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_a !== 36'd0) begin
      n_fail++; $display("FAIL rstmid async: got %h want %h", obs_a, 36'd0);
    end
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs_a !== 36'd0) begin
      n_fail++; $display("FAIL rstmid idle: got %h want %h", obs_a, 36'd0);
    end
    pulse_run_a();
    @(negedge clk);
    want = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'd10);
    n_checks++;
    if (obs_a !== want) begin
      n_fail++; $display("FAIL rstmid restart: got %h want %h", obs_a, want);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_duty_bounds();
    logic [35:0] want;
    // duty 0: no valid slots but counters and data still advance
    cfg_a(32'd5, 16'd2, 16'd0, 16'd0, 32'd100, 32'd1, 7'd0);
    pulse_run_a();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) want = mk(1'b0, i == 1, 1'b1, 1'b0, 32'd5 + 32'(i));
      else       want = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd6);
      n_checks++;
      if (obs_a !== want) begin
        n_fail++; $display("FAIL duty0 slot %0d: got %h want %h", i, obs_a, want);
      end
    end
    cfg_a(32'd5, 16'd2, 16'd7, 16'd0, 32'd100, 32'd1, 7'd0);
    pulse_run_a();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      want = mk(1'b1, i == 1, 1'b1, 1'b0, 32'd5 + 32'(i));
      n_checks++;
      if (obs_a !== want) begin
        n_fail++; $display("FAIL dutybig slot %0d: got %h want %h", i, obs_a, want);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_run_priority();
    logic [35:0] want;
    cfg_a(32'd10, 16'd4, 16'd4, 16'd0, 32'd100, 32'd3, 7'd0);
    pulse_run_a();
    repeat (4) @(negedge clk);
    want = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'd19);
    n_checks++;
    if (obs_a !== want) begin
      n_fail++; $display("FAIL prio last: got %h want %h", obs_a, want);
    end
    run_a = 1'b1; start_a = 32'd100;
    @(posedge clk); #1 run_a = 1'b0;
    @(negedge clk);
    want = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'd100);
    n_checks++;
    if (obs_a !== want) begin
      n_fail++; $display("FAIL prio restart: got %h want %h", obs_a, want);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_wrap8();
    logic [7:0]  ed [3] = '{8'd250, 8'd254, 8'd2};
    logic [11:0] want;
    per = 16'd3; duty = 16'd3; delay = 7'd0; start_b = 8'd250; step_b = 8'd4;
    @(posedge clk); #1 run_b = 1'b1;
    @(posedge clk); #1 run_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) want = {1'b1, i == 2, 1'b1, 1'b0, ed[i]};
      else       want = {4'b0001, 8'd2};
      n_checks++;
      if (obs_b !== want) begin
        n_fail++; $display("FAIL wrap8 slot %0d: got %h want %h", i, obs_b, want);
      end
    end
  endtask

`ifdef GENERATOR_N_CONTINUOUS_EN
  task automatic test_continuous();
    logic [31:0] ed [10] = '{32'd10, 32'd13, 32'd16, 32'd19, 32'd10, 32'd13, 32'd16, 32'd19,
                             32'd19, 32'd19};
    logic [35:0] want;
    cfg_a(32'd10, 16'd4, 16'd4, 16'd0, 32'd100, 32'd3, 7'd0);
    cont = 1'b1;
    pulse_run_a();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 8) want = mk(1'b1, (i == 3) || (i == 7), 1'b1, 1'b0, ed[i]);
      else       want = mk(1'b0, 1'b0, 1'b0, 1'b1, ed[i]);
      n_checks++;
      if (obs_a !== want) begin
        n_fail++; $display("FAIL cont slot %0d: got %h want %h", i, obs_a, want);
      end
      if (i == 5) cont = 1'b0;
    end
  endtask
`endif

  initial begin
    rst_n = 1'b1; run_a = 1'b0; run_b = 1'b0; ready = 1'b1; cont = 1'b0;
    start_a = '0; start_b = '0; per = '0; duty = '0; iter = '0; delay = '0;
    step_a = '0; step_b = '0;
    test_reset();
    test_basic();
    test_nested();
    test_stall();
    test_reset_mid();
    test_duty_bounds();
    test_run_priority();
    test_wrap8();
`ifdef GENERATOR_N_CONTINUOUS_EN
    test_continuous();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
